pll_seq_ctrl: RTL and testbench
===============================

// Module: pll_seq_ctrl
// PURPOSE
// - Power-up/lock sequencer sitting directly upstream of the PLL core; drives its en and fbdiv inputs and consumes its lock output.
// - Brings the PLL up after a settle delay, waits for lock with a timeout, and retries a bounded number of times.
// - Restarts the PLL on lock loss or on a feedback-divider change; reports ready/fault to the system.
// PARAMETERS
// - SETTLE_CYCLES  16  rclk cycles pll_en is held low after start_req before first enable (>=1)
// - OFF_CYCLES     4   rclk cycles pll_en is held low on each restart (>=2, guarantees core reset)
// - LOCK_TIMEOUT   256 rclk cycles allowed in WAIT_LOCK before a retry (>=1)
// - MAX_RETRIES    3   restarts allowed per start before FAULT (0 = no retries)
// - DEFAULT_FBDIV  8   pll_fbdiv / shadow value after reset (1..255)
// PORTS
// - rclk         in   1  reference clock; also the PLL core reference; the only clock
// - rst_n        in   1  synchronous active-low reset, sampled on posedge rclk
// - start_req    in   1  level; 1 = PLL wanted running, 0 = power PLL down
// - fbdiv_in     in   8  requested feedback divider
// - fbdiv_load   in   1  1-cycle strobe; captures fbdiv_in into the shadow register
// - pll_lock     in   1  lock from PLL core (rclk domain, used unsynchronised)
// - pll_en       out  1  enable to PLL core
// - pll_fbdiv    out  8  divider to PLL core; changes only while pll_en=0
// - ready        out  1  1 while in LOCKED
// - fault        out  1  1 while in FAULT
// - lock_lost    out  1  sticky; set on lock loss in LOCKED, cleared when start_req=0 or by reset
// - retry_cnt    out  2  restarts consumed since last start (saturates at 3)
// BEHAVIOUR
// - Reset (rst_n=0 at posedge): state OFF, all counters 0, pll_en=0, ready=0, fault=0, lock_lost=0, retry_cnt=0, shadow=pll_fbdiv=DEFAULT_FBDIV.
// - Single clock; Moore FSM with registered outputs; all outputs change one cycle after the deciding edge.
// - States: OFF, SETTLE, WAIT_LOCK, LOCKED, RESTART, FAULT. One cycle counter, cleared on every state change.
// - OFF: pll_en=0. start_req=1 -> SETTLE; retry_cnt and lock_lost cleared.
// - SETTLE: pll_en=0 for SETTLE_CYCLES cycles, then -> WAIT_LOCK.
// - WAIT_LOCK: pll_en=1. pll_lock=1 -> LOCKED. After LOCK_TIMEOUT cycles without lock: retry_cnt<MAX_RETRIES -> RESTART with retry_cnt+1; otherwise -> FAULT.
// - LOCKED: pll_en=1, ready=1. pll_lock=0 -> set lock_lost; -> RESTART (retry_cnt+1, or FAULT if exhausted). fbdiv_load -> RESTART (retry_cnt unchanged).
// - RESTART: pll_en=0 for OFF_CYCLES cycles, then -> WAIT_LOCK with a fresh timeout.
// - FAULT: pll_en=0, fault=1. Left only via start_req=0 -> OFF.
// - start_req=0 in any state -> OFF on the next edge; highest priority over lock, timeout and load.
// - Same-cycle priority: start_req=0 > pll_lock edge/timeout > fbdiv_load.
// - Shadow: fbdiv_load captures fbdiv_in in any state; fbdiv_in=0 is stored as 1.
// - pll_fbdiv <= shadow on every cycle the registered pll_en is 0, so the core never sees a divider change while enabled.
// - fbdiv_load in WAIT_LOCK also forces RESTART (no retry consumed); timeout and lock take precedence that cycle, and the value is still captured.
// - Counters sized $clog2(max(SETTLE_CYCLES,OFF_CYCLES,LOCK_TIMEOUT))+1 bits; retry_cnt saturates, never wraps.
// - rst_n=0 mid-sequence: immediate return to reset state on that edge; pll_en drops the next cycle.
// TESTING
// - Reset, start_req=1, pll_lock model asserts 40 cycles after pll_en rises -> pll_en rises at cycle 17, ready=1 one cycle after lock, retry_cnt=0.
// - pll_lock never asserts, MAX_RETRIES=3 -> 4 timeouts of 256 cycles with 4-cycle RESTART gaps, retry_cnt 1,2,3, then fault=1, pll_en=0; start_req=0 -> OFF, fault=0.
// - In LOCKED, drop pll_lock 1 cycle -> lock_lost=1, ready=0, pll_en low for exactly 4 cycles, relock -> ready=1, lock_lost stays 1.
// - In LOCKED, fbdiv_load with fbdiv_in=20 -> RESTART, pll_fbdiv changes 8->20 only while pll_en=0, retry_cnt unchanged; fbdiv_in=0 loads as 1.
// - Same cycle: start_req=0, pll_lock falls and fbdiv_load=1 -> next state OFF, pll_en=0, shadow updated.
// - rst_n=0 during WAIT_LOCK at cycle 100 -> all outputs at reset values next cycle, pll_fbdiv=DEFAULT_FBDIV.

Source files
------------

// File: rtl/pll_seq_ctrl_if.sv
// pll_seq_ctrl_if
// Groups the sequencer's system-side and PLL-core-side signals.
//   start_req  : 1 = PLL wanted running, 0 = power the PLL down
//   fbdiv_in   : requested feedback divider
//   fbdiv_load : 1-cycle strobe that captures fbdiv_in into the shadow register
//   pll_lock   : lock indication from the PLL core
//   pll_en     : enable to the PLL core
//   pll_fbdiv  : divider to the PLL core
//   ready      : PLL is locked and usable
//   fault      : lock attempts exhausted
//   lock_lost  : sticky, lock dropped while locked since the last start
//   retry_cnt  : restarts consumed since the last start (saturating)
// master drives requests and lock (system + PLL side); slave is the sequencer.
interface pll_seq_ctrl_if;
  logic       start_req;
  logic [7:0] fbdiv_in;
  logic       fbdiv_load;
  logic       pll_lock;
  logic       pll_en;
  logic [7:0] pll_fbdiv;
  logic       ready;
  logic       fault;
  logic       lock_lost;
  logic [1:0] retry_cnt;

  modport master (
    output start_req, fbdiv_in, fbdiv_load, pll_lock,
    input  pll_en, pll_fbdiv, ready, fault, lock_lost, retry_cnt
  );

  modport slave (
    input  start_req, fbdiv_in, fbdiv_load, pll_lock,
    output pll_en, pll_fbdiv, ready, fault, lock_lost, retry_cnt
  );
endinterface

// File: rtl/pll_seq_ctrl.sv
// pll_seq_ctrl
// Power-up / lock sequencer in front of a PLL core. After start_req it holds
// the core off for a settle delay, enables it and waits for lock with a
// timeout, retrying a bounded number of times before declaring a fault. Lock
// loss or a divider change restarts the core. All outputs are registered and
// change on the same edge as the state that decides them.
// Ports:
//   rclk  : reference clock (also the PLL reference); the only clock
//   rst_n : synchronous active-low reset
//   bus   : pll_seq_ctrl_if.slave (requests/lock in, enable/divider/status out)
module pll_seq_ctrl #(
  parameter int SETTLE_CYCLES = 16,
  parameter int OFF_CYCLES    = 4,
  parameter int LOCK_TIMEOUT  = 256,
  parameter int MAX_RETRIES   = 3,
  parameter int DEFAULT_FBDIV = 8
) (
  input  logic           rclk,
  input  logic           rst_n,
  pll_seq_ctrl_if.slave  bus
);

  localparam int MAX_AB   = (SETTLE_CYCLES > OFF_CYCLES) ? SETTLE_CYCLES : OFF_CYCLES;
  localparam int MAX_WAIT = (MAX_AB > LOCK_TIMEOUT) ? MAX_AB : LOCK_TIMEOUT;
  localparam int CW       = $clog2(MAX_WAIT) + 1;
  // Wide enough to hold MAX_RETRIES itself; the output view saturates at 3.
  localparam int RW       = $clog2(MAX_RETRIES + 2) + 1;

  localparam logic [CW-1:0] SETTLE_LAST  = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] OFF_LAST     = CW'(OFF_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
  localparam logic [RW-1:0] RETRY_MAX    = RW'(MAX_RETRIES);
  localparam logic [7:0]    FBDIV_RST    = 8'(DEFAULT_FBDIV);

  typedef enum logic [2:0] {
    S_OFF, S_SETTLE, S_WAIT_LOCK, S_LOCKED, S_RESTART, S_FAULT
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] retries_q, retries_d;
  logic          lock_lost_q, lock_lost_d;
  logic [7:0]    shadow_q, shadow_d;
  logic          pll_en_q, ready_q, fault_q;
  logic [1:0]    retry_cnt_q;
  logic [7:0]    pll_fbdiv_q;

  // A failed lock attempt either restarts (consuming a retry) or gives up.
  function automatic state_t retry_or_fault(input logic [RW-1:0] used);
    return (used < RETRY_MAX) ? S_RESTART : S_FAULT;
  endfunction

  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    state_d     = state_q;
    cnt_d       = cnt_q;
    retries_d   = retries_q;
    lock_lost_d = lock_lost_q;
    shadow_d    = shadow_q;

    // Divider capture is independent of state; zero is not a legal divider.
    if (bus.fbdiv_load)
      shadow_d = (bus.fbdiv_in == 8'd0) ? 8'd1 : bus.fbdiv_in;

    if (!bus.start_req) begin
      state_d     = S_OFF;
      lock_lost_d = 1'b0;
    end else begin
      case (state_q)
        S_OFF: begin
          state_d     = S_SETTLE;
          retries_d   = '0;
          lock_lost_d = 1'b0;
        end
        S_SETTLE: begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == SETTLE_LAST) state_d = S_WAIT_LOCK;
        end
        S_WAIT_LOCK: begin
          cnt_d = cnt_q + CW'(1);
          // pll_lock is already in the rclk domain, so it is used directly.
          if (bus.pll_lock) begin
            state_d = S_LOCKED;
          end else if (cnt_q == TIMEOUT_LAST) begin
            state_d = retry_or_fault(retries_q);
            if (retries_q < RETRY_MAX) retries_d = retries_q + RW'(1);
          end else if (bus.fbdiv_load) begin
            state_d = S_RESTART;
          end
        end
        S_LOCKED: begin
          if (!bus.pll_lock) begin
            lock_lost_d = 1'b1;
            state_d     = retry_or_fault(retries_q);
            if (retries_q < RETRY_MAX) retries_d = retries_q + RW'(1);
          end else if (bus.fbdiv_load) begin
            state_d = S_RESTART;
          end
        end
        S_RESTART: begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == OFF_LAST) state_d = S_WAIT_LOCK;
        end
        S_FAULT: state_d = S_FAULT;
        default: state_d = S_OFF;
      endcase
    end

    // Single shared counter restarts from zero in every new state.
    if (state_d != state_q) cnt_d = '0;
  end

  always_ff @(posedge rclk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      state_q     <= S_OFF;
      cnt_q       <= '0;
      retries_q   <= '0;
      lock_lost_q <= 1'b0;
      shadow_q    <= FBDIV_RST;
      pll_en_q    <= 1'b0;
      ready_q     <= 1'b0;
      fault_q     <= 1'b0;
      retry_cnt_q <= 2'd0;
      pll_fbdiv_q <= FBDIV_RST;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retries_q   <= retries_d;
      lock_lost_q <= lock_lost_d;
      shadow_q    <= shadow_d;
      // Outputs are decoded from the next state so they are registered yet
      // appear together with the state they belong to.
      pll_en_q    <= (state_d == S_WAIT_LOCK) || (state_d == S_LOCKED);
      ready_q     <= (state_d == S_LOCKED);
      fault_q     <= (state_d == S_FAULT);
      retry_cnt_q <= (retries_d > RW'(3)) ? 2'd3 : retries_d[1:0];
      // The core only ever sees a new divider while it is held disabled.
      if (!pll_en_q) pll_fbdiv_q <= shadow_q;
    end
  end

  assign bus.pll_en    = pll_en_q;
  assign bus.pll_fbdiv = pll_fbdiv_q;
  assign bus.ready     = ready_q;
  assign bus.fault     = fault_q;
  assign bus.lock_lost = lock_lost_q;
  assign bus.retry_cnt = retry_cnt_q;

endmodule

// File: tb/tb_pll_seq_ctrl.sv
// tb_pll_seq_ctrl
// Directed scenarios followed by randomized stimulus, with every cycle's
// outputs compared against a deadline-based reference model of the sequencer.
module tb_pll_seq_ctrl;
  localparam int SETTLE  = 16;
  localparam int OFFC    = 4;
  localparam int TIMEOUT = 256;
  localparam int MAXR    = 3;
  localparam int DEF     = 8;

  logic rclk = 1'b0;
  logic rst_n;

  pll_seq_ctrl_if bus ();

  pll_seq_ctrl #(
    .SETTLE_CYCLES (SETTLE),
    .OFF_CYCLES    (OFFC),
    .LOCK_TIMEOUT  (TIMEOUT),
    .MAX_RETRIES   (MAXR),
    .DEFAULT_FBDIV (DEF)
  ) dut (
    .rclk  (rclk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 rclk = ~rclk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: tracks whether the PLL should be enabled and the edge
  // number at which the current off-period or lock window ends.
  int         t_edge     = 0;
  bit         m_on       = 0;
  bit         m_en       = 0;
  bit         m_locked   = 0;
  bit         m_fault    = 0;
  bit         m_lost     = 0;
  int         m_retries  = 0;
  int         m_deadline = 0;
  logic [7:0] m_shadow   = 8'(DEF);
  logic [7:0] m_fbdiv    = 8'(DEF);

  task automatic model_step();
    logic [7:0] old_shadow;
    bit         old_en;
    bit         failed;
    old_shadow = m_shadow;
    old_en     = m_en;
    failed     = 0;
    t_edge++;
    if (!rst_n) begin
      m_on = 0; m_en = 0; m_locked = 0; m_fault = 0; m_lost = 0;
      m_retries = 0; m_shadow = 8'(DEF); m_fbdiv = 8'(DEF);
      return;
    end
    if (bus.fbdiv_load) m_shadow = (bus.fbdiv_in == 8'd0) ? 8'd1 : bus.fbdiv_in;
    if (!old_en) m_fbdiv = old_shadow;
    if (!bus.start_req) begin
      m_on = 0; m_en = 0; m_locked = 0; m_fault = 0; m_lost = 0;
    end else if (!m_on) begin
      m_on = 1; m_retries = 0; m_lost = 0; m_deadline = t_edge + SETTLE;
    end else if (m_fault) begin
      m_en = 0;
    end else if (!m_en) begin
      if (t_edge == m_deadline) begin
        m_en = 1; m_deadline = t_edge + TIMEOUT;
      end
    end else begin
      if (m_locked && !bus.pll_lock) begin
        failed = 1; m_lost = 1;
      end else if (!m_locked && bus.pll_lock) begin
        m_locked = 1;
      end else if (!m_locked && t_edge == m_deadline) begin
        failed = 1;
      end else if (bus.fbdiv_load) begin
        m_locked = 0; m_en = 0; m_deadline = t_edge + OFFC;
      end
      if (failed) begin
        m_locked = 0; m_en = 0;
        if (m_retries < MAXR) begin
          m_retries++; m_deadline = t_edge + OFFC;
        end else begin
          m_fault = 1;
        end
      end
    end
  endtask

  function automatic logic [31:0] model_vec();
    logic [1:0] sat;
    sat = (m_retries > 3) ? 2'd3 : 2'(m_retries);
    return {18'd0, m_en, m_locked, m_fault, m_lost, sat, m_fbdiv};
  endfunction

  function automatic logic [31:0] dut_vec();
    return {18'd0, bus.pll_en, bus.ready, bus.fault, bus.lock_lost, bus.retry_cnt, bus.pll_fbdiv};
  endfunction

  // Simple PLL core: locks lock_delay cycles after enable, unless forced off.
  int en_age     = 0;
  int lock_delay = 40;
  bit drop_lock  = 0;

  task automatic tick();
    if (!bus.pll_en) en_age = 0;
    else             en_age++;
    bus.pll_lock = bus.pll_en && (en_age >= lock_delay) && !drop_lock;
    @(posedge rclk);
    model_step();
    @(negedge rclk);
    check("outs", dut_vec(), model_vec());
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (!bus.ready && n < 500) begin tick(); n++; end
    check(tag, 32'(bus.ready), 32'd1);
  endtask

  initial begin
    int n;
    rst_n          = 1'b0;
    bus.start_req  = 1'b0;
    bus.fbdiv_in   = 8'd0;
    bus.fbdiv_load = 1'b0;
    bus.pll_lock   = 1'b0;
    repeat (3) tick();
    check("reset_vec", dut_vec(), {18'd0, 4'b0000, 2'd0, 8'd8});
    rst_n = 1'b1;
    tick();

    // Power-up: enable after the settle delay, lock 40 cycles later.
    lock_delay = 40;
    bus.start_req = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!bus.pll_en && n < 100);
    check("en_rise_cycle", 32'(n), 32'd17);
    wait_ready("first_lock");
    check("first_retry", 32'(bus.retry_cnt), 32'd0);

    // One-cycle lock drop while locked.
    drop_lock = 1; tick(); drop_lock = 0;
    check("drop_ready", 32'(bus.ready), 32'd0);
    check("drop_lost", 32'(bus.lock_lost), 32'd1);
    n = 0;
    while (!bus.pll_en && n < 50) begin tick(); n++; end
    check("restart_low", 32'(n), 32'(OFFC));
    wait_ready("relock");
    check("lost_sticky", 32'(bus.lock_lost), 32'd1);
    check("drop_retry", 32'(bus.retry_cnt), 32'd1);

    // Divider change while locked.
    bus.fbdiv_in = 8'd20; bus.fbdiv_load = 1'b1; tick(); bus.fbdiv_load = 1'b0;
    check("load_en_off", 32'(bus.pll_en), 32'd0);
    check("fbdiv_held", 32'(bus.pll_fbdiv), 32'd8);
    tick();
    check("fbdiv_new", 32'(bus.pll_fbdiv), 32'd20);
    check("load_retry", 32'(bus.retry_cnt), 32'd1);
    wait_ready("relock_20");
    bus.fbdiv_in = 8'd0; bus.fbdiv_load = 1'b1; tick(); bus.fbdiv_load = 1'b0;
    tick();
    check("fbdiv_zero", 32'(bus.pll_fbdiv), 32'd1);
    wait_ready("relock_1");

    // start_req=0, lock loss and load all in one cycle.
    bus.start_req = 1'b0; drop_lock = 1; bus.fbdiv_in = 8'd33; bus.fbdiv_load = 1'b1;
    tick();
    bus.fbdiv_load = 1'b0; drop_lock = 0;
    check("prio_en", 32'(bus.pll_en), 32'd0);
    check("prio_ready", 32'(bus.ready), 32'd0);
    check("prio_lost", 32'(bus.lock_lost), 32'd0);
    tick();
    check("prio_shadow", 32'(bus.pll_fbdiv), 32'd33);

    // No lock ever: four timeouts, then fault.
    lock_delay = 100000;
    bus.start_req = 1'b1;
    n = 0;
    while (!bus.fault && n < 2000) begin tick(); n++; end
    check("fault_cycle", 32'(n), 32'(1 + SETTLE + (MAXR + 1) * TIMEOUT + MAXR * OFFC));
    check("fault_retry", 32'(bus.retry_cnt), 32'd3);
    check("fault_en", 32'(bus.pll_en), 32'd0);
    bus.start_req = 1'b0; tick();
    check("fault_clear", 32'(bus.fault), 32'd0);

    // Reset in the middle of WAIT_LOCK.
    bus.start_req = 1'b1; bus.fbdiv_in = 8'd50; bus.fbdiv_load = 1'b1; tick();
    bus.fbdiv_load = 1'b0;
    repeat (99) tick();
    check("mid_en", 32'(bus.pll_en), 32'd1);
    check("mid_fbdiv", 32'(bus.pll_fbdiv), 32'd50);
    rst_n = 1'b0; tick();
    check("mid_reset_vec", dut_vec(), {18'd0, 4'b0000, 2'd0, 8'd8});
    rst_n = 1'b1; bus.start_req = 1'b0; tick();

    // Randomized stimulus against the model.
    for (int i = 0; i < 4000; i++) begin
      rst_n          = ($urandom_range(0, 999) != 0);
      bus.start_req  = ($urandom_range(0, 299) != 0);
      bus.fbdiv_load = ($urandom_range(0, 79) == 0);
      bus.fbdiv_in   = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      drop_lock      = ($urandom_range(0, 149) == 0);
      if (!bus.pll_en)
        lock_delay = ($urandom_range(0, 3) == 0) ? 1000 : int'($urandom_range(1, 60));
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
